matrix_sequencer: RTL

MATRIX_SEQUENCER -- requirements
Module: matrix_sequencer

---
 rtl/matrix_pkg.sv | 24 ++
 rtl/matrix_sequencer_if.sv | 31 +++
 rtl/matseq_operand_rf.sv | 41 ++++
 rtl/matrix_sequencer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and small helpers for the 3x3 matrix sequencer.
package matrix_pkg;

    localparam int unsigned MAT_N      = 3;
    localparam int unsigned MAT_ELEMS  = 9;
    localparam int unsigned LOAD_WORDS = 18;
    localparam int unsigned LOAD_CNT_W = 5;
    localparam int unsigned ELEM_CNT_W = 4;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_e;

    function automatic logic is_last_elem(input logic [ELEM_CNT_W-1:0] k);
        return k == ELEM_CNT_W'(MAT_ELEMS - 1);
    endfunction

    function automatic logic is_last_load(input logic [LOAD_CNT_W-1:0] k);
        return k == LOAD_CNT_W'(LOAD_WORDS - 1);
    endfunction

endpackage

// File: rtl/matrix_sequencer_if.sv
// Operand/result streams plus the link to the external combinational multiplier.
interface matrix_sequencer_if
    import matrix_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic                        in_valid;
    logic                        in_ready;
    logic [WIDTH-1:0]            in_data;
    logic [MAT_ELEMS*WIDTH-1:0]  mm_a;
    logic [MAT_ELEMS*WIDTH-1:0]  mm_b;
    logic [ELEM_CNT_W-1:0]       mm_index;
    logic [WIDTH-1:0]            mm_c;
    logic                        out_valid;
    logic                        out_ready;
    logic [WIDTH-1:0]            out_data;
    logic                        out_last;
    logic                        busy;

    // Sequencer side
    modport slave (
        input  in_valid, in_data, mm_c, out_ready,
        output in_ready, mm_a, mm_b, mm_index, out_valid, out_data, out_last, busy
    );

    // Environment side: operand source, multiplier and result sink
    modport master (
        output in_valid, in_data, mm_c, out_ready,
        input  in_ready, mm_a, mm_b, mm_index, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/matseq_operand_rf.sv
// 18-entry operand register file: slots 0..8 hold A, slots 9..17 hold B, both row-major.
module matseq_operand_rf
    import matrix_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [LOAD_CNT_W-1:0]      waddr,
    input  logic [WIDTH-1:0]           wdata,
    output logic [MAT_ELEMS*WIDTH-1:0] mm_a,
    output logic [MAT_ELEMS*WIDTH-1:0] mm_b
);

    logic [WIDTH-1:0] mem_q [LOAD_WORDS];
    logic [WIDTH-1:0] mem_d [LOAD_WORDS];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(LOAD_WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar k = 0; k < int'(MAT_ELEMS); k++) begin : g_pack
        assign mm_a[k*WIDTH +: WIDTH] = mem_q[k];
        assign mm_b[k*WIDTH +: WIDTH] = mem_q[k + int'(MAT_ELEMS)];
    end

endmodule

// File: rtl/matrix_sequencer.sv
// LOAD/CALC/SEND sequencer feeding an external 3x3 multiplier one result index per cycle.
// Optional synchronous abort input `clear` is present when MATSEQ_CLEAR_EN is defined.
module matrix_sequencer
    import matrix_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
`ifdef MATSEQ_CLEAR_EN
    input  logic clear,
`endif
    matrix_sequencer_if.slave bus
);

    state_e                  state_q, state_d;
    logic [LOAD_CNT_W-1:0]   load_cnt_q, load_cnt_d;
    logic [ELEM_CNT_W-1:0]   calc_cnt_q, calc_cnt_d;
    logic [ELEM_CNT_W-1:0]   send_cnt_q, send_cnt_d;
    logic [WIDTH-1:0]        res_q [MAT_ELEMS];
    logic [WIDTH-1:0]        res_d [MAT_ELEMS];
    logic [WIDTH-1:0]        out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic                    in_ready_q, in_ready_d;
    logic                    busy_q, busy_d;
    logic                    rf_we;

    matseq_operand_rf #(
        .WIDTH (WIDTH)
    ) u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (rf_we),
        .waddr (load_cnt_q),
        .wdata (bus.in_data),
        .mm_a  (bus.mm_a),
        .mm_b  (bus.mm_b)
    );

    // Next-state, counters and registered output values
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        calc_cnt_d = calc_cnt_q;
        send_cnt_d = send_cnt_q;
        res_d      = res_q;
        rf_we      = 1'b0;

        case (state_q)
            LOAD: begin
                if (bus.in_valid && in_ready_q) begin
                    rf_we = 1'b1;
                    if (is_last_load(load_cnt_q)) begin
                        load_cnt_d = '0;
                        state_d    = CALC;
                    end else begin
                        load_cnt_d = load_cnt_q + LOAD_CNT_W'(1);
                    end
                end
            end
            CALC: begin
                res_d[calc_cnt_q] = bus.mm_c;
                if (is_last_elem(calc_cnt_q)) begin
                    calc_cnt_d = '0;
                    send_cnt_d = '0;
                    state_d    = SEND;
                end else begin
                    calc_cnt_d = calc_cnt_q + ELEM_CNT_W'(1);
                end
            end
            SEND: begin
                if (out_valid_q && bus.out_ready) begin
                    if (is_last_elem(send_cnt_q)) begin
                        send_cnt_d = '0;
                        state_d    = LOAD;
                    end else begin
                        send_cnt_d = send_cnt_q + ELEM_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d    = LOAD;
                load_cnt_d = '0;
                calc_cnt_d = '0;
                send_cnt_d = '0;
            end
        endcase

`ifdef MATSEQ_CLEAR_EN
        // Abort keeps operands and results; only sequencing state is dropped
        if (clear) begin
            state_d    = LOAD;
            load_cnt_d = '0;
            calc_cnt_d = '0;
            send_cnt_d = '0;
            res_d      = res_q;
            rf_we      = 1'b0;
        end
`endif

        in_ready_d  = (state_d == LOAD);
        busy_d      = (state_d != LOAD);
        out_valid_d = (state_d == SEND);
        out_last_d  = (state_d == SEND) && is_last_elem(send_cnt_d);
        out_data_d  = res_d[send_cnt_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            load_cnt_q  <= '0;
            calc_cnt_q  <= '0;
            send_cnt_q  <= '0;
            for (int i = 0; i < int'(MAT_ELEMS); i++) begin
                res_q[i] <= '0;
            end
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            calc_cnt_q  <= calc_cnt_d;
            send_cnt_q  <= send_cnt_d;
            res_q       <= res_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    // calc_cnt is held at zero outside CALC, so it doubles as the multiplier index
    assign bus.mm_index  = calc_cnt_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;

endmodule
